// File: rtl/reg_wr_select_arb_if.sv
// reg_wr_select_arb_if
//   Bundles the request and response signals of the register-file write-select
//   arbiter. Clock and reset stay outside as plain ports.
//
//   Signals
//     hold        : pipeline stall; no request is accepted while it is high
//     a_valid/a_addr/a_ready : channel A request handshake
//     b_valid/b_addr/b_ready : channel B request handshake
//     select_line : registered write select into the register file
//     viol        : one-cycle pulse, a protected write was dropped
//     viol_cnt    : saturating count of dropped protected writes
//
//   Modports
//     master : the requesting pipeline, which drives requests and sees responses
//     slave  : the arbiter
interface reg_wr_select_arb_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic                hold;
    logic                a_valid;
    logic [ADDR_W-1:0]   a_addr;
    logic                a_ready;
    logic                b_valid;
    logic [ADDR_W-1:0]   b_addr;
    logic                b_ready;
    logic [NUM_REGS-1:0] select_line;
    logic                viol;
    logic [CNT_W-1:0]    viol_cnt;

    modport master (
        output hold, a_valid, a_addr, b_valid, b_addr,
        input  a_ready, b_ready, select_line, viol, viol_cnt
    );

    modport slave (
        input  hold, a_valid, a_addr, b_valid, b_addr,
        output a_ready, b_ready, select_line, viol, viol_cnt
    );
endinterface

// File: rtl/reg_wr_select_arb.sv
// reg_wr_select_arb
//   Registered write-select arbiter for a register file. Two pipeline channels
//   (A, B) present register addresses with a valid/ready handshake. Requests to
//   the same address are resolved by a fairness toggle. Writes to protected
//   registers are accepted but their select bit is suppressed, and they are
//   reported through a violation pulse and a saturating counter.
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : reg_wr_select_arb_if.slave
//             (hold, a_valid/a_addr/a_ready, b_valid/b_addr/b_ready,
//              select_line, viol, viol_cnt)
module reg_wr_select_arb #(
    parameter int                     ADDR_W       = 4,
    parameter logic [(2**ADDR_W)-1:0] PROTECT_MASK = {{((2**ADDR_W)-1){1'b0}}, 1'b1},
    parameter int                     CNT_W        = 8
) (
    input logic                clk,
    input logic                rst_n,
    reg_wr_select_arb_if.slave bus
);
    localparam int NUM_REGS = 2**ADDR_W;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e               prio_q, prio_d;
    logic [NUM_REGS-1:0] select_line_q, select_line_d;
    logic                viol_q, viol_d;
    logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;

    logic       conflict;
    logic       a_ready, b_ready;
    logic       a_fire, b_fire;
    logic       a_hit, b_hit;
    logic [1:0] hits;

    // Adds 0..2 to the counter and sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
        onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction

    // Accept logic: on a same-address conflict only the priority holder is
    // ready; the loser sees ready=0 and must hold its request.
    always_comb begin
        conflict = bus.a_valid && bus.b_valid && (bus.a_addr == bus.b_addr);
        a_ready  = rst_n && !bus.hold && !(conflict && (prio_q == PRIO_B));
        b_ready  = rst_n && !bus.hold && !(conflict && (prio_q == PRIO_A));
        a_fire   = bus.a_valid && a_ready;
        b_fire   = bus.b_valid && b_ready;
        // A conflict lets only one channel fire, so a protected conflict
        // counts once, for the winner.
        a_hit    = a_fire && PROTECT_MASK[bus.a_addr];
        b_hit    = b_fire && PROTECT_MASK[bus.b_addr];
        hits     = {1'b0, a_hit} + {1'b0, b_hit};
    end

    // Priority FSM: flips after every conflict it resolves, so the loser
    // wins the next conflicting cycle.
    always_comb begin
        prio_d = prio_q;
        if (conflict && !bus.hold) begin
            case (prio_q)
                PRIO_A: prio_d = PRIO_B;
                PRIO_B: prio_d = PRIO_A;
            endcase
        end
    end

    always_comb begin
        select_line_d = '0;
        if (a_fire) begin
            select_line_d = select_line_d | onehot(bus.a_addr);
        end
        if (b_fire) begin
            select_line_d = select_line_d | onehot(bus.b_addr);
        end
        select_line_d = select_line_d & ~PROTECT_MASK;
        viol_d        = a_hit || b_hit;
        viol_cnt_d    = sat_add(viol_cnt_q, hits);
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q        <= PRIO_A;
            select_line_q <= '0;
            viol_q        <= 1'b0;
            viol_cnt_q    <= '0;
        end else begin
            prio_q        <= prio_d;
            select_line_q <= select_line_d;
            viol_q        <= viol_d;
            viol_cnt_q    <= viol_cnt_d;
        end
    end

    assign bus.a_ready     = a_ready;
    assign bus.b_ready     = b_ready;
    assign bus.select_line = select_line_q;
    assign bus.viol        = viol_q;
    assign bus.viol_cnt    = viol_cnt_q;
endmodule

// File: doc/reg_wr_select_arb.md
Name: reg_wr_select_arb

Overview:
- Parametrised, registered successor to the register-file write-select decoder.
- Accepts write requests from two pipeline channels (A, B), each a register address with a valid/ready handshake.
- Resolves same-address conflicts with a fairness toggle and filters writes to write-protected registers.
- Drives a registered one-hot (or two-hot) select vector into the register file, plus a protection-violation pulse and a saturating violation counter.

Parameters:
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W is a derived localparam.
- PROTECT_MASK, 16'h0001, NUM_REGS-bit mask; a 1 marks a write-protected register (default: R0 read-only).
- CNT_W, 8, width of the violation counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- hold  input  1  pipeline stall; when 1, no request is accepted.
- a_valid  input  1  channel A request valid.
- a_addr  input  ADDR_W  channel A target register.
- a_ready  output  1  channel A accepted this cycle (combinational).
- b_valid  input  1  channel B request valid.
- b_addr  input  ADDR_W  channel B target register.
- b_ready  output  1  channel B accepted this cycle (combinational).
- select_line  output  NUM_REGS  registered write select to the register file.
- viol  output  1  registered one-cycle pulse: a protected write was dropped.
- viol_cnt  output  CNT_W  saturating count of dropped protected writes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - select_line=0, viol=0, viol_cnt=0, prio=A (internal 1-bit priority register).
  - Reset overrides all requests in that cycle, and nothing is accepted.
  - a_ready/b_ready are forced 0 while rst_n=0.
- Accept rules (combinational, same cycle):
  - conflict = a_valid & b_valid & (a_addr==b_addr).
  - a_ready = rst_n & ~hold & ~(conflict & prio==B).
  - b_ready = rst_n & ~hold & ~(conflict & prio==A).
  - ready is independent of valid except through conflict; a transfer occurs when valid&ready.
- Priority state machine, 2 states A/B, updated only when a conflict occurs with hold=0:
  - In state A, A wins; next state is B.
  - In state B, B wins; next state is A.
  - Without a conflict, or while hold=1, prio holds.
  - A stalled channel must keep valid and addr stable; it is guaranteed service within 1 further conflicting cycle.
- Select generation (registered, latency 1):
  - On each edge, select_line <= OR over accepted channels of (1<<addr) & ~PROTECT_MASK.
  - Different addresses from A and B both accepted gives two bits set.
  - No transfer gives select_line=0 next cycle, so every bit is a single-cycle pulse.
- Protection:
  - An accepted transfer to a protected address is still accepted (ready=1), but its select bit is suppressed.
  - viol <= 1 for one cycle if either accepted channel hit a protected register.
  - viol_cnt increments by the number of protected hits that cycle (0, 1 or 2), saturating at 2**CNT_W-1 with no wrap.
  - A conflicting request to a protected address counts once, for the winner only.
- hold=1 gives no transfers, so select_line=0 and viol=0 on the next cycle; prio and viol_cnt are unchanged.
- Reset mid-operation: a stalled B request is discarded, and the upstream must re-present it after reset.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, no valids -> select_line=16'h0000, viol=0, viol_cnt=0; a_ready=b_ready=1.
- Dual distinct: a_addr=3, b_addr=9, both valid for 1 cycle -> both ready=1; next cycle select_line=16'h0208, then 16'h0000.
- Conflict fairness: a_addr=b_addr=5, both valid held for 3 cycles -> cycle1 a_ready=1/b_ready=0, cycle2 b_ready=1/a_ready=0, cycle3 A again; select_line=16'h0020 on each following cycle.
- Protection: a_addr=0 valid for 1 cycle -> a_ready=1; next cycle select_line=0, viol=1, viol_cnt=1. Then repeat 300 protected writes with CNT_W=8 -> viol_cnt saturates at 255.
- Hold: hold=1 with a_addr=7, b_addr=2 valid -> a_ready=b_ready=0, select_line stays 0. Release hold -> select_line=16'h0084 one cycle later.
- Reset mid-stall: conflict on addr 4 (B stalled), then assert rst_n=0 for 1 cycle -> select_line=0, prio=A, and no B write is emitted after reset.
